ysyx_24110015_skid_buf: RTL and testbench

YSYX_24110015_SKID_BUF -- requirements
Module: ysyx_24110015_skid_buf

---
 rtl/ysyx_24110015_pkg.sv | 11 +
 rtl/ysyx_24110015_Reg.sv | 21 ++
 rtl/ysyx_24110015_skid_buf.sv | 111 +++++++++++
 tb/tb_ysyx_24110015_skid_buf.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110015_pkg.sv
// rtl/ysyx_24110015_pkg.sv - shared occupancy-state encoding for the skid buffer
package ysyx_24110015_pkg;

  localparam int STATE_W = 2;

  // The state value equals the number of buffered entries, so count is the state itself.
  localparam logic [STATE_W-1:0] EMPTY = 2'd0;
  localparam logic [STATE_W-1:0] ONE   = 2'd1;
  localparam logic [STATE_W-1:0] FULL  = 2'd2;

endpackage

// File: rtl/ysyx_24110015_Reg.sv
// rtl/ysyx_24110015_Reg.sv - generic register with synchronous reset and write enable
module ysyx_24110015_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_24110015_skid_buf.sv
// rtl/ysyx_24110015_skid_buf.sv - two-entry skid buffer; YSYX_24110015_SKID_FLUSH_EN adds a flush input
module ysyx_24110015_skid_buf
  import ysyx_24110015_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef YSYX_24110015_SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_n;
  logic               state_wen;
  logic [WIDTH-1:0]   main_q;
  logic [WIDTH-1:0]   main_n;
  logic               main_wen;
  logic [WIDTH-1:0]   skid_q;
  logic               skid_wen;
  logic               in_fire;
  logic               out_fire;
  logic               flush_act;

`ifdef YSYX_24110015_SKID_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // in_ready comes only from registered state and rst, which breaks the ready path.
  assign in_ready  = (state != FULL) & ~rst;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_n  = state;
    main_n   = in_data;
    main_wen = 1'b0;
    skid_wen = 1'b0;
    if (flush_act) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_wen = 1'b1;
            state_n  = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_wen = 1'b1;
          end else if (in_fire) begin
            skid_wen = 1'b1;
            state_n  = FULL;
          end else if (out_fire) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_n   = skid_q;
            main_wen = 1'b1;
            state_n  = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  assign state_wen = (state_n != state);

  ysyx_24110015_Reg #(.WIDTH(STATE_W), .RESET_VAL(EMPTY)) u_state (
    .clk  (clk),
    .rst  (rst),
    .din  (state_n),
    .dout (state),
    .wen  (state_wen)
  );

  ysyx_24110015_Reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk  (clk),
    .rst  (rst),
    .din  (main_n),
    .dout (main_q),
    .wen  (main_wen)
  );

  ysyx_24110015_Reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .din  (in_data),
    .dout (skid_q),
    .wen  (skid_wen)
  );

endmodule

// File: tb/tb_ysyx_24110015_skid_buf.sv
// tb/tb_ysyx_24110015_skid_buf.sv - self-checking bench for the skid buffer
module tb_ysyx_24110015_skid_buf;

  localparam int          W    = 32;
  localparam logic [31:0] RVAL = 32'h0000_5A5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    count;
`ifdef YSYX_24110015_SKID_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] q[$];

  ysyx_24110015_skid_buf #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef YSYX_24110015_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of capacity two; a push is allowed only while fewer than two entries are held.
  always @(posedge clk) begin : model
    bit ofire;
    bit ifire;
    ofire = (q.size() > 0) && out_ready;
    ifire = in_valid && (q.size() < 2);
    if (rst) q.delete();
`ifdef YSYX_24110015_SKID_FLUSH_EN
    else if (flush) q.delete();
`endif
    else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("mon_count", {30'd0, count}, q.size());
      chk("mon_in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) && !rst});
      if (q.size() > 0) chk("mon_out_data", out_data, q[0]);
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_in_ready2", {31'd0, in_ready}, 32'd0);
    chk("rst_out_data", out_data, RVAL);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // streaming
    step(1'b1, 32'h1, 1'b1);
    chk("stream_d1", out_data, 32'h1);
    chk("stream_c1", {30'd0, count}, 32'd1);
    step(1'b1, 32'h2, 1'b1);
    chk("stream_d2", out_data, 32'h2);
    step(1'b1, 32'h3, 1'b1);
    chk("stream_d3", out_data, 32'h3);
    chk("stream_c3", {30'd0, count}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    // backpressure
    step(1'b1, 32'h10, 1'b0);
    step(1'b1, 32'h20, 1'b0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_count", {30'd0, count}, 32'd2);
    step(1'b1, 32'h30, 1'b0);
    chk("bp_hold", out_data, 32'h10);
    step(1'b1, 32'h30, 1'b1);
    chk("bp_d20", out_data, 32'h20);
    step(1'b1, 32'h30, 1'b1);
    chk("bp_d30", out_data, 32'h30);
    chk("bp_c30", {30'd0, count}, 32'd1);
    step(1'b0, 32'h0, 1'b1);

    // simultaneous fire in ONE
    step(1'b1, 32'h5, 1'b0);
    chk("sim_d5", out_data, 32'h5);
    step(1'b1, 32'h6, 1'b1);
    chk("sim_d6", out_data, 32'h6);
    chk("sim_c", {30'd0, count}, 32'd1);
    step(1'b0, 32'h0, 1'b1);

    // mid-operation reset
    step(1'b1, 32'h7, 1'b0);
    step(1'b1, 32'h8, 1'b0);
    chk("mid_full", {30'd0, count}, 32'd2);
    rst = 1'b1;
    step(1'b1, 32'hEE, 1'b1);
    chk("mid_count", {30'd0, count}, 32'd0);
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_data", out_data, RVAL);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

`ifdef YSYX_24110015_SKID_FLUSH_EN
    step(1'b1, 32'hA, 1'b0);
    step(1'b1, 32'hB, 1'b0);
    flush = 1'b1;
    step(1'b1, 32'h9, 1'b0);
    chk("flush_count", {30'd0, count}, 32'd0);
    flush = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    chk("flush_no9", {31'd0, out_valid}, 32'd0);
    step(1'b1, 32'hC, 1'b0);
    rst = 1'b1; flush = 1'b1;
    step(1'b1, 32'hD, 1'b1);
    chk("flush_rst_data", out_data, RVAL);
    chk("flush_rst_count", {30'd0, count}, 32'd0);
    rst = 1'b0; flush = 1'b0;
    step(1'b0, 32'h0, 1'b1);
`endif

    // mixed traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    chk("final_empty", {30'd0, count}, 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
